mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester and the data requester driven from the EX/MEM pipeline register outputs (load/store).
- Sequences each access with a req/ready handshake to memory.
- Raises a pipeline stall while a data access is outstanding.
- Data side has priority; a burst limiter keeps fetch from being starved.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-priority fetch/data arbiter for a single-port memory; MEM_TIMEOUT_EN adds a wait-cycle abort with a sticky timeout flag
module mem_port_arbiter #(
    parameter int BURST_LIMIT    = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic [15:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        dm_rd_i,
    input  logic        dm_wr_i,
    input  logic [15:0] dm_addr_i,
    input  logic [15:0] dm_wdata_i,
    output logic [15:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        timeout_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam int BW = $clog2(BURST_LIMIT + 1);
    localparam logic [BW-1:0] B_MAX = BW'(BURST_LIMIT);

    logic [1:0] state;
    logic [BW-1:0] burst;
    logic dm_req, busy, done, decide, grant_dm, grant_if;
    logic [15:0] done_rdata;

    assign dm_req = dm_rd_i | dm_wr_i;
    assign busy   = state != S_IDLE;

`ifdef MEM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] T_MAX = WW'(TIMEOUT_CYCLES);
    logic [WW-1:0] wcnt;
    logic tmo_hit, tmo_q;
    assign tmo_hit    = busy & ~mem_ready_i & (wcnt == T_MAX);
    assign done       = busy & (mem_ready_i | tmo_hit);
    assign done_rdata = mem_ready_i ? mem_rdata_i : 16'hFFFF;
    assign timeout_o  = tmo_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wcnt  <= decide ? '0 : (busy & ~mem_ready_i) ? wcnt + 1'b1 : wcnt;
            tmo_q <= tmo_q | tmo_hit;
        end
    end
`else
    assign done       = busy & mem_ready_i;
    assign done_rdata = mem_rdata_i;
    assign timeout_o  = 1'b0;
`endif

    // Arbitration also runs in the completion cycle so back-to-back accesses have no bubble
    assign decide   = ~busy | done;
    assign grant_dm = dm_req & (~if_req_i | (burst != B_MAX));
    assign grant_if = if_req_i & ~grant_dm;

    assign if_valid_o = done & (state == S_FETCH);
    assign dm_valid_o = done & (state == S_DATA);
    assign if_rdata_o = if_valid_o ? done_rdata : 16'd0;
    assign dm_rdata_o = dm_valid_o ? done_rdata : 16'd0;
    assign stall_o    = dm_req & ~dm_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 16'd0;
            mem_wdata_o <= 16'd0;
        end else if (decide) begin
            state       <= grant_dm ? S_DATA : grant_if ? S_FETCH : S_IDLE;
            mem_req_o   <= grant_dm | grant_if;
            mem_we_o    <= grant_dm & dm_wr_i;
            mem_addr_o  <= grant_dm ? dm_addr_i : grant_if ? if_addr_i : mem_addr_o;
            mem_wdata_o <= grant_dm ? dm_wdata_i : mem_wdata_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            burst <= '0;
        else if (~if_req_i | (decide & grant_if))
            burst <= '0;
        else if (decide & grant_dm & (burst != B_MAX))
            burst <= burst + 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a transaction-level arbitration model
module tb_mem_port_arbiter;
    localparam int BL = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic if_req_i, dm_rd_i, dm_wr_i, mem_ready_i;
    logic [15:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [15:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic if_valid_o, dm_valid_o, stall_o, mem_req_o, mem_we_o, timeout_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
        .dm_rd_i(dm_rd_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .timeout_o(timeout_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit data;
        bit we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } acc_t;

    acc_t q[$];
    bit sb_on = 0, rec_on = 0, act_busy = 0, nxt_busy = 0;
    logic [9:0] obs = '0;
    int nobs = 0;
    bit p_if = 0, p_rd = 0, p_wr = 0, frd = 0;
    logic [15:0] p_iaddr = '0, p_daddr = '0, p_wdata = '0, frdata = '0, cur_rdata = '0;
    int fw = -1, burst = 0, wl = 0, ncomp = 0;

    // One cycle of requesters + memory + reference arbitration; grants push expected accesses
    task automatic step();
        acc_t a;
        bit gd, gf;
        @(posedge clk_i); #1;
        act_busy = nxt_busy;
        if_req_i = p_if; if_addr_i = p_iaddr;
        dm_rd_i = p_rd; dm_wr_i = p_wr; dm_addr_i = p_daddr; dm_wdata_i = p_wdata;
        mem_ready_i = act_busy && (wl == 0);
        mem_rdata_i = mem_ready_i ? cur_rdata : 16'($urandom);
        if (mem_ready_i) ncomp++;
        if (act_busy && !mem_ready_i) wl--;
        nxt_busy = act_busy && !mem_ready_i;
        if (!nxt_busy) begin
            gd = (p_rd || p_wr) && (!p_if || burst < BL);
            gf = p_if && !gd;
            if (gd || gf) begin
                a.data = gd; a.we = gd && p_wr;
                a.addr = gd ? p_daddr : p_iaddr;
                a.wdata = gd ? p_wdata : 16'd0;
                a.rdata = frd ? frdata : 16'($urandom);
                q.push_back(a);
                cur_rdata = a.rdata;
                wl = (fw >= 0) ? fw : $urandom_range(0, 3);
                nxt_busy = 1;
            end
            if (gf) burst = 0;
            else if (gd && p_if && burst < BL) burst++;
        end
        if (!p_if) burst = 0;
    endtask

    task automatic run_phase(input int k);
        int start;
        start = ncomp;
        for (int c = 0; c < 300 && ncomp < start + k; c++) step();
        if (ncomp < start + k) chk("phase_progress", ncomp - start, k);
        p_if = 0; p_rd = 0; p_wr = 0;
        for (int c = 0; c < 20 && nxt_busy; c++) step();
        step();
    endtask

    always @(negedge clk_i) begin
        acc_t a;
        bit edv, eiv;
        edv = 0; eiv = 0;
        if (sb_on) begin
            chk("mem_req", mem_req_o, act_busy);
            chk("timeout_idle", timeout_o, 0);
            if (act_busy) begin
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    a = q[0];
                    edv = mem_ready_i && a.data;
                    eiv = mem_ready_i && !a.data;
                    chk("mem_we", mem_we_o, a.we);
                    chk("mem_addr", mem_addr_o, a.addr);
                    if (a.data) chk("mem_wdata", mem_wdata_o, a.wdata);
                    chk("dm_valid", dm_valid_o, edv);
                    chk("if_valid", if_valid_o, eiv);
                    chk("dm_rdata", dm_rdata_o, edv ? a.rdata : 16'd0);
                    chk("if_rdata", if_rdata_o, eiv ? a.rdata : 16'd0);
                    if (mem_ready_i) begin
                        void'(q.pop_front());
                        if (rec_on && nobs < 10) begin
                            obs = {obs[8:0], a.data};
                            nobs++;
                        end
                    end
                end
            end else begin
                chk("dm_valid_idle", dm_valid_o, 0);
                chk("if_valid_idle", if_valid_o, 0);
            end
            chk("stall", stall_o, (dm_rd_i | dm_wr_i) & ~edv);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        if_req_i = 0; dm_rd_i = 0; dm_wr_i = 0; mem_ready_i = 0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_valids", {if_valid_o, dm_valid_o}, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_i = 0;

        dm_rd_i = 1; dm_addr_i = 16'h1111;
        @(posedge clk_i); #1;
        chk("mid_grant_req", mem_req_o, 1);
        chk("mid_grant_addr", mem_addr_o, 16'h1111);
        #2 rst_i = 1;
        #1;
        chk("mid_rst_req", mem_req_o, 0);
        chk("mid_rst_addr", mem_addr_o, 0);
        chk("mid_rst_dm_valid", dm_valid_o, 0);
        dm_rd_i = 0;
        @(posedge clk_i); #1 rst_i = 0;
        @(posedge clk_i); #1;
        chk("mid_rst_idle", mem_req_o, 0);

        dm_rd_i = 1; dm_addr_i = 16'h2222;
`ifdef MEM_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 30 && !dm_valid_o; i++) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_rdata", dm_rdata_o, 16'hFFFF);
        dm_rd_i = 0;
        @(posedge clk_i); #1;
        chk("tmo_flag", timeout_o, 1);
        repeat (3) @(posedge clk_i);
        #1 chk("tmo_sticky", timeout_o, 1);
`else
        n = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (dm_valid_o) n++;
        end
        chk("no_tmo_valids", n, 0);
        chk("no_tmo_flag", timeout_o, 0);
        chk("no_tmo_req", mem_req_o, 1);
        dm_rd_i = 0;
`endif
        rst_i = 1;
        @(posedge clk_i); #1 rst_i = 0;
        sb_on = 1;

        p_if = 1; p_iaddr = 16'h0040; fw = 3; frd = 1; frdata = 16'hA5A5;
        run_phase(1);
        frd = 0; fw = -1;
        p_if = 1; p_iaddr = 16'h0080; p_wr = 1; p_daddr = 16'h0100; p_wdata = 16'h1234;
        run_phase(2);
        p_rd = 1; p_wr = 1; p_daddr = 16'h0200; p_wdata = 16'hBEEF;
        run_phase(2);
        p_if = 1; p_rd = 1; p_iaddr = 16'h0300; p_daddr = 16'h0400; fw = 0; rec_on = 1; nobs = 0;
        run_phase(10);
        rec_on = 0; fw = -1;
        chk("starve_pattern", obs, 10'b1111011110);

        for (int ph = 0; ph < 40; ph++) begin
            p_if = 1'($urandom); p_rd = 1'($urandom); p_wr = 1'($urandom);
            if (!p_if && !p_rd && !p_wr) p_if = 1;
            p_iaddr = 16'($urandom); p_daddr = 16'($urandom); p_wdata = 16'($urandom);
            run_phase($urandom_range(1, 6));
        end
        chk("sb_drained", q.size(), 0);
        sb_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
